el2_dec_tlu_trigger_csr: RTL

EL2_DEC_TLU_TRIGGER_CSR -- requirements
Module: el2_dec_tlu_trigger_csr

---
 rtl/el2_pkg.sv | 39 +++
 rtl/el2_dec_trig_reg.sv | 68 ++++++
 rtl/rvdff.sv | 17 +
 rtl/rvdffe.sv | 20 ++
 rtl/el2_dec_tlu_trigger_csr.sv | 91 +++++++++
 5 files changed

// File: rtl/el2_pkg.sv
// Shared debug-trigger types: CSR addresses, trigger match packet and legalised mcontrol fields.
package el2_pkg;

  localparam logic [11:0] CSR_TSELECT = 12'h7a0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7a1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7a2;
  localparam int          NUM_TRIG    = 4;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } el2_trigger_pkt_t;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } el2_mcontrol_t;

  // type=2 (mcontrol) and maskmax=31 are hardwired; everything else comes from storage.
  function automatic logic [31:0] mcontrol_rd(input el2_mcontrol_t mc);
    return {4'h2, mc.dmode, 6'd31, mc.hit, mc.select, 6'b0,
            mc.action, mc.chain, 3'b0, mc.match, mc.m, 3'b0,
            mc.execute, mc.store, mc.load};
  endfunction

endpackage

// File: rtl/el2_dec_trig_reg.sv
// One trigger's tdata1/tdata2 storage with write legalisation and hit-bit update.
// Latency: writes and hit pulses visible one cycle later.  Backpressure: none; locked writes are dropped.
module el2_dec_trig_reg
  import el2_pkg::*;
#(
  parameter logic CHAIN_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          dbg_in_debug_mode,
  input  logic          wr_tdata1,
  input  logic          wr_tdata2,
  input  logic [31:0]   wrdata,
  input  logic          update_hit,
  input  logic          chain_lock,
  output el2_mcontrol_t mcontrol,
  output logic [31:0]   tdata2
);

  logic          lock;
  logic          wr1_ok;
  logic          mc_en;
  logic [9:0]    mc_q;
  el2_mcontrol_t mc_wr;
  el2_mcontrol_t mc_nxt;

  assign mcontrol = el2_mcontrol_t'(mc_q);

  // A debug-mode-owned trigger is read-only to machine-mode software.
  assign lock   = mcontrol.dmode & ~dbg_in_debug_mode;
  assign wr1_ok = wr_tdata1 & ~lock;
  assign mc_en  = wr1_ok | update_hit;

  always_comb begin
    mc_wr         = '0;
    mc_wr.dmode   = wrdata[27] & dbg_in_debug_mode;
    mc_wr.hit     = wrdata[20] | update_hit;
    mc_wr.select  = wrdata[19];
    mc_wr.action  = wrdata[12] & (wrdata[15:13] == 3'b000) & mc_wr.dmode;
    mc_wr.chain   = CHAIN_EN & (chain_lock ? mcontrol.chain : wrdata[11]);
    mc_wr.match   = wrdata[7] & (wrdata[10:8] == 3'b000);
    mc_wr.m       = wrdata[6];
    mc_wr.execute = wrdata[2];
    mc_wr.store   = wrdata[1];
    mc_wr.load    = wrdata[0];

    mc_nxt     = mcontrol;
    mc_nxt.hit = mcontrol.hit | update_hit;
    if (wr1_ok) mc_nxt = mc_wr;
  end

  rvdffe #(.WIDTH(10)) mc_ff (
    .din   (mc_nxt),
    .en    (mc_en),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (mc_q)
  );

  rvdffe #(.WIDTH(32)) tdata2_ff (
    .din   (wrdata),
    .en    (wr_tdata2 & ~lock),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (tdata2)
  );

endmodule

// File: rtl/rvdff.sv
// Plain flop bank.
// Latency: one cycle.  Backpressure: none.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end

endmodule

// File: rtl/rvdffe.sv
// Flop bank with load enable.
// Latency: one cycle.  Backpressure: holds value while en is low.
module rvdffe #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  rvdff #(.WIDTH(WIDTH)) dff (
    .din   (en ? din : dout),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (dout)
  );

endmodule

// File: rtl/el2_dec_tlu_trigger_csr.sv
// Debug trigger CSR block: tselect plus four mcontrol/tdata2 triggers feeding the match logic.
// Latency: writes visible next cycle, reads combinational.  Backpressure: none.
module el2_dec_tlu_trigger_csr
  import el2_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   dec_csr_wen_r,
  input  logic [11:0]            dec_csr_waddr_r,
  input  logic [31:0]            dec_csr_wrdata_r,
  input  logic [11:0]            dec_csr_rdaddr_d,
  input  logic                   dbg_in_debug_mode,
  input  logic [3:0]             update_hit_bit_r,
  output el2_trigger_pkt_t [3:0] trigger_pkt_any,
  output logic [1:0]             trigger_chain,
  output logic [3:0]             trigger_action,
  output logic [31:0]            trigger_csr_rddata_d,
  output logic                   trigger_csr_hit_d
);

  logic [1:0]    tselect;
  logic          tsel_wen;
  logic [3:0]    wr_tdata1;
  logic [3:0]    wr_tdata2;
  logic [3:0]    chain_lock;
  el2_mcontrol_t mc [NUM_TRIG];
  logic [31:0]   tdata2 [NUM_TRIG];

  // Out-of-range selects leave tselect unchanged.
  assign tsel_wen = dec_csr_wen_r & (dec_csr_waddr_r == CSR_TSELECT) &
                    (dec_csr_wrdata_r[31:2] == 30'b0);

  rvdffe #(.WIDTH(2)) tselect_ff (
    .din   (dec_csr_wrdata_r[1:0]),
    .en    (tsel_wen),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (tselect)
  );

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    assign wr_tdata1[i] = dec_csr_wen_r & (dec_csr_waddr_r == CSR_TDATA1) & (tselect == 2'(i));
    assign wr_tdata2[i] = dec_csr_wen_r & (dec_csr_waddr_r == CSR_TDATA2) & (tselect == 2'(i));

    // Chain on an even trigger links it to the next one, so the partner's owner guards it.
    if (i % 2 == 0) begin : g_lock
      assign chain_lock[i] = mc[i+1].dmode & ~dbg_in_debug_mode;
    end else begin : g_nolock
      assign chain_lock[i] = 1'b0;
    end

    el2_dec_trig_reg #(.CHAIN_EN(i % 2 == 0)) trig_reg (
      .clk               (clk),
      .rst_l             (rst_l),
      .dbg_in_debug_mode (dbg_in_debug_mode),
      .wr_tdata1         (wr_tdata1[i]),
      .wr_tdata2         (wr_tdata2[i]),
      .wrdata            (dec_csr_wrdata_r),
      .update_hit        (update_hit_bit_r[i]),
      .chain_lock        (chain_lock[i]),
      .mcontrol          (mc[i]),
      .tdata2            (tdata2[i])
    );

    assign trigger_pkt_any[i] = '{select:  mc[i].select,
                                  match:   mc[i].match,
                                  store:   mc[i].store,
                                  load:    mc[i].load,
                                  execute: mc[i].execute,
                                  m:       mc[i].m,
                                  tdata2:  tdata2[i]};
    assign trigger_action[i] = mc[i].action;
  end

  assign trigger_chain = {mc[2].chain, mc[0].chain};

  assign trigger_csr_hit_d = (dec_csr_rdaddr_d == CSR_TSELECT) |
                             (dec_csr_rdaddr_d == CSR_TDATA1)  |
                             (dec_csr_rdaddr_d == CSR_TDATA2);

  always_comb begin
    trigger_csr_rddata_d = '0;
    case (dec_csr_rdaddr_d)
      CSR_TSELECT: trigger_csr_rddata_d = {30'b0, tselect};
      CSR_TDATA1:  trigger_csr_rddata_d = mcontrol_rd(mc[tselect]);
      CSR_TDATA2:  trigger_csr_rddata_d = tdata2[tselect];
      default:     trigger_csr_rddata_d = '0;
    endcase
  end

endmodule
